// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall / bubble sequencer for the five-stage core.
// Turns hazard-unit stall requests, EX redirects and memory waits into
// per-stage enable, flush and bubble controls for PC, IF/ID and ID/EX.
// The unit also keeps a saturating count of cycles lost to hazard bubbles.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | pipeline flowing; a stall_req starts a bubble sequence
// STALL | bubble sequence in progress; stall_counter is the position
module pipeline_stall_ctrl #(
    parameter int unsigned STALL_CYCLES = 2,
    parameter int unsigned CNT_W        = 2,
    parameter int unsigned PERF_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_req,
    input  logic              flush_req,
    input  logic              mem_wait,
    input  logic              perf_clr,
    output logic [CNT_W-1:0]  stall_counter,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_en,
    output logic              id_ex_bubble,
    output logic              stall_active,
    output logic [PERF_W-1:0] stall_cycles
);

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  stall_counter_q, stall_counter_d;
    logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;

    // State, sequence position and perf counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            stall_counter_q <= '0;
            stall_cycles_q  <= '0;
        end else begin
            state_q         <= state_d;
            stall_counter_q <= stall_counter_d;
            stall_cycles_q  <= stall_cycles_d;
        end
    end

    // Next-state: mem_wait freezes everything, flush aborts, stall sequences
    always_comb begin
        state_d         = state_q;
        stall_counter_d = stall_counter_q;
        if (mem_wait) begin
            state_d         = state_q;
            stall_counter_d = stall_counter_q;
        end else if (flush_req) begin
            state_d         = IDLE;
            stall_counter_d = '0;
        end else if (state_q == STALL) begin
            if (stall_counter_q == CNT_LAST) begin
                state_d         = IDLE;
                stall_counter_d = '0;
            end else begin
                stall_counter_d = stall_counter_q + CNT_ONE;
            end
        end else if (stall_req) begin
            // A single-cycle stall never leaves IDLE.
            if (STALL_CYCLES > 1) begin
                state_d         = STALL;
                stall_counter_d = CNT_ONE;
            end
        end
    end

    // Stage controls, combinational from state and requests (zero latency)
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_bubble = 1'b0;
        stall_active = 1'b0;
        if (mem_wait) begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            id_ex_en = 1'b0;
        end else if (flush_req) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if ((state_q == STALL) || stall_req) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
            stall_active = 1'b1;
        end
    end

    // Saturating bubble-cycle counter; clear wins over increment
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (perf_clr) begin
            stall_cycles_d = '0;
        end else if (stall_active && (stall_cycles_q != {PERF_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + PERF_W'(1);
        end
    end

    assign stall_counter = stall_counter_q;
    assign stall_cycles  = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl. Three instances share stimulus:
// default parameters, PERF_W = 4 (saturation) and STALL_CYCLES = 3 (reset
// mid-stall). Inputs change 1 ns after posedge; outputs are checked at negedge.
module tb_pipeline_stall_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall_req = 1'b0;
    logic flush_req = 1'b0;
    logic mem_wait = 1'b0;
    logic perf_clr = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    logic [1:0]  d_cnt;
    logic        d_pc, d_ifen, d_iffl, d_idex, d_bub, d_act;
    logic [31:0] d_cyc;

    logic [1:0]  p_cnt;
    logic        p_pc, p_ifen, p_iffl, p_idex, p_bub, p_act;
    logic [3:0]  p_cyc;

    logic [1:0]  s_cnt;
    logic        s_pc, s_ifen, s_iffl, s_idex, s_bub, s_act;
    logic [31:0] s_cyc;

    always #5 clk = ~clk;

    pipeline_stall_ctrl u_def (
        .clk(clk), .rst_n(rst_n), .stall_req(stall_req), .flush_req(flush_req),
        .mem_wait(mem_wait), .perf_clr(perf_clr), .stall_counter(d_cnt),
        .pc_en(d_pc), .if_id_en(d_ifen), .if_id_flush(d_iffl), .id_ex_en(d_idex),
        .id_ex_bubble(d_bub), .stall_active(d_act), .stall_cycles(d_cyc)
    );

    pipeline_stall_ctrl #(.PERF_W(4)) u_p4 (
        .clk(clk), .rst_n(rst_n), .stall_req(stall_req), .flush_req(flush_req),
        .mem_wait(mem_wait), .perf_clr(perf_clr), .stall_counter(p_cnt),
        .pc_en(p_pc), .if_id_en(p_ifen), .if_id_flush(p_iffl), .id_ex_en(p_idex),
        .id_ex_bubble(p_bub), .stall_active(p_act), .stall_cycles(p_cyc)
    );

    pipeline_stall_ctrl #(.STALL_CYCLES(3)) u_sc3 (
        .clk(clk), .rst_n(rst_n), .stall_req(stall_req), .flush_req(flush_req),
        .mem_wait(mem_wait), .perf_clr(perf_clr), .stall_counter(s_cnt),
        .pc_en(s_pc), .if_id_en(s_ifen), .if_id_flush(s_iffl), .id_ex_en(s_idex),
        .id_ex_bubble(s_bub), .stall_active(s_act), .stall_cycles(s_cyc)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock cycle: apply inputs after posedge, return at negedge.
    task automatic drive(input logic s, input logic f, input logic m, input logic c);
        @(posedge clk);
        #1;
        stall_req = s;
        flush_req = f;
        mem_wait  = m;
        perf_clr  = c;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        stall_req = 1'b0;
        flush_req = 1'b0;
        mem_wait  = 1'b0;
        perf_clr  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        chk("rst_cnt", 32'(d_cnt), 32'd0);
        chk("rst_en", {29'd0, d_pc, d_ifen, d_idex}, 32'h7);
        chk("rst_flush_bub_act", {29'd0, d_iffl, d_bub, d_act}, 32'h0);
        chk("rst_cyc", d_cyc, 32'd0);

        // Default stall: two bubble cycles, counter 0 then 1
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        chk("st1_ctl", {26'd0, d_pc, d_ifen, d_idex, d_bub, d_act, d_iffl}, 32'b001110);
        chk("st1_cnt", 32'(d_cnt), 32'd0);
        drive(0, 0, 0, 0);
        chk("st2_ctl", {26'd0, d_pc, d_ifen, d_idex, d_bub, d_act, d_iffl}, 32'b001110);
        chk("st2_cnt", 32'(d_cnt), 32'd1);
        drive(0, 0, 0, 0);
        chk("st_end_ctl", {26'd0, d_pc, d_ifen, d_idex, d_bub, d_act, d_iffl}, 32'b111000);
        chk("st_end_cnt", 32'(d_cnt), 32'd0);
        chk("st_end_cyc", d_cyc, 32'd2);
        chk("sc3_third_bubble", {29'd0, s_pc, s_bub, s_act}, 32'b011);
        chk("sc3_third_cnt", 32'(s_cnt), 32'd2);

        // Back-to-back: new request in first IDLE cycle after a stall
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        chk("b2b_cnt", 32'(d_cnt), 32'd1);
        drive(1, 0, 0, 0);
        chk("b2b_fresh_ctl", {29'd0, d_pc, d_bub, d_act}, 32'b011);
        chk("b2b_fresh_cnt", 32'(d_cnt), 32'd0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("b2b_cyc", d_cyc, 32'd6);

        // mem_wait mid-stall stretches without consuming bubbles
        do_reset();
        drive(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0);
            chk("mw_ctl", {26'd0, d_pc, d_ifen, d_idex, d_bub, d_act, d_iffl}, 32'b000000);
            chk("mw_cnt", 32'(d_cnt), 32'd1);
        end
        chk("mw_cyc_hold", d_cyc, 32'd1);
        drive(0, 0, 0, 0);
        chk("mw_last_bubble", {29'd0, d_pc, d_bub, d_act}, 32'b011);
        drive(0, 0, 0, 0);
        chk("mw_idle_ctl", {29'd0, d_pc, d_bub, d_act}, 32'b100);
        chk("mw_idle_cnt", 32'(d_cnt), 32'd0);
        chk("mw_cyc", d_cyc, 32'd2);

        // Flush aborts an in-progress stall
        do_reset();
        drive(1, 0, 0, 0);
        drive(0, 1, 0, 0);
        chk("fl_ctl", {26'd0, d_pc, d_ifen, d_idex, d_bub, d_act, d_iffl}, 32'b111101);
        drive(0, 0, 0, 0);
        chk("fl_idle_cnt", 32'(d_cnt), 32'd0);
        chk("fl_idle_pc", 32'(d_pc), 32'd1);
        chk("fl_cyc", d_cyc, 32'd1);

        // Flush and stall together in IDLE: flush response only
        drive(1, 1, 0, 0);
        chk("fs_ctl", {26'd0, d_pc, d_ifen, d_idex, d_bub, d_act, d_iffl}, 32'b111101);
        drive(0, 0, 0, 0);
        chk("fs_next_ctl", {29'd0, d_pc, d_bub, d_act}, 32'b100);
        chk("fs_cnt", 32'(d_cnt), 32'd0);
        chk("fs_cyc", d_cyc, 32'd1);

        // Saturation of a 4-bit perf counter, then clear during a stall
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            drive(1, 0, 0, 0);
            drive(0, 0, 0, 0);
            drive(0, 0, 0, 0);
            if (k == 7) chk("sat_14", 32'(p_cyc), 32'd14);
            if (k == 8) chk("sat_15", 32'(p_cyc), 32'd15);
        end
        chk("sat_hold", 32'(p_cyc), 32'd15);
        drive(1, 0, 0, 1);
        chk("clr_same_cycle", 32'(p_cyc), 32'd15);
        drive(0, 0, 0, 0);
        chk("clr_zero", 32'(p_cyc), 32'd0);
        chk("clr_bubble", 32'(p_act), 32'd1);
        drive(0, 0, 0, 0);
        chk("clr_resume", 32'(p_cyc), 32'd1);

        // Reset mid-stall with STALL_CYCLES = 3
        do_reset();
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("sc3_cnt2", 32'(s_cnt), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("sc3_rst_cnt", 32'(s_cnt), 32'd0);
        chk("sc3_rst_cyc", s_cyc, 32'd0);
        chk("sc3_rst_en", {29'd0, s_pc, s_ifen, s_idex}, 32'h7);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 0, 0, 0);
        chk("sc3_after_rst", {29'd0, s_pc, s_bub, s_act}, 32'b100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
